mux_scan: RTL and testbench

MUX_SCAN -- requirements
Module: mux_scan

---
 rtl/mux_scan.sv | 132 +++++++++++++
 tb/tb_mux_scan.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan.sv
// Channel multiplexer with direct select and timed auto-scan of N channels onto LEDR.
// Define MUX_SCAN_PAUSE_EN to add the KEY[1] step/pause pushbutton and the PAUSE state.
module mux_scan #(
    parameter int unsigned W        = 4,
    parameter int unsigned N        = 4,
    parameter int unsigned SCAN_DIV = 50000000,
    localparam int unsigned SELW    = (N > 2) ? $clog2(N) : 1
) (
    input  logic                CLOCK_50,
    input  logic [1:0]          KEY,
    input  logic [N*W-1:0]      SW,
    input  logic [SELW-1:0]     sel,
    input  logic                mode,
    output logic [W-1:0]        LEDR,
    output logic [SELW-1:0]     ch,
    output logic                chg
);

    localparam int unsigned   DIVW     = $clog2(SCAN_DIV);
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(SCAN_DIV - 1);
    localparam logic [SELW-1:0] CH_LAST  = SELW'(N - 1);

    typedef enum logic [1:0] {StDirect, StScan, StPause} state_e;

    logic rst_n;
    logic step;

    assign rst_n = KEY[0];

`ifdef MUX_SCAN_PAUSE_EN
    logic key_meta_q, key_sync_q, key_prev_q;

    // Flops reset to the released level so reset release never looks like a press.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            key_meta_q <= 1'b1;
            key_sync_q <= 1'b1;
            key_prev_q <= 1'b1;
        end else begin
            key_meta_q <= KEY[1];
            key_sync_q <= key_meta_q;
            key_prev_q <= key_sync_q;
        end
    end

    assign step = key_prev_q & ~key_sync_q;
`else
    logic unused_key;

    assign unused_key = KEY[1];
    assign step       = 1'b0;
`endif

    state_e          state_q, state_d;
    logic [DIVW-1:0] div_q, div_d;
    logic [SELW-1:0] ch_q, ch_d;
    logic [W-1:0]    led_q, led_d;
    logic            chg_q, chg_d;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        ch_d    = ch_q;
        // mode=0 overrides everything, including a coincident step pulse.
        if (!mode) begin
            state_d = StDirect;
            div_d   = '0;
            if (32'(sel) < N) begin
                ch_d = sel;
            end
        end else begin
            unique case (state_q)
                StDirect: begin
                    state_d = StScan;
                    div_d   = '0;
                end
                StScan: begin
                    if (step) begin
                        state_d = StPause;
                    end else if (div_q == DIV_LAST) begin
                        div_d = '0;
                        ch_d  = (ch_q == CH_LAST) ? '0 : ch_q + SELW'(1);
                    end else begin
                        div_d = div_q + DIVW'(1);
                    end
                end
                StPause: begin
                    if (step) begin
                        state_d = StScan;
                        div_d   = '0;
                    end
                end
                default: begin
                    state_d = StDirect;
                    div_d   = '0;
                end
            endcase
        end
    end

    // LEDR follows the channel that ch is about to hold, so both change on the same edge.
    always_comb begin
        led_d = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (ch_d == SELW'(k)) begin
                led_d = SW[k*W +: W];
            end
        end
        chg_d = (ch_d != ch_q);
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StDirect;
            div_q   <= '0;
            ch_q    <= '0;
            led_q   <= '0;
            chg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            ch_q    <= ch_d;
            led_q   <= led_d;
            chg_q   <= chg_d;
        end
    end

    assign LEDR = led_q;
    assign ch   = ch_q;
    assign chg  = chg_q;

endmodule

// File: tb/tb_mux_scan.sv
// Directed self-checking bench for mux_scan (N=4 main instance, N=3 instance for the sel clamp).
module tb_mux_scan;

    logic        clk = 1'b0;
    logic [1:0]  key;
    logic [15:0] sw;
    logic [1:0]  sel;
    logic        mode;
    logic [3:0]  ledr;
    logic [1:0]  ch;
    logic        chg;

    logic [11:0] sw3;
    logic [1:0]  sel3;
    logic [3:0]  ledr3;
    logic [1:0]  ch3;
    logic        chg3;

    int checks = 0;
    int errors = 0;
    int moved;

    always #5 clk = ~clk;

    mux_scan #(.W(4), .N(4), .SCAN_DIV(4)) dut (
        .CLOCK_50 (clk),
        .KEY      (key),
        .SW       (sw),
        .sel      (sel),
        .mode     (mode),
        .LEDR     (ledr),
        .ch       (ch),
        .chg      (chg)
    );

    mux_scan #(.W(4), .N(3), .SCAN_DIV(4)) dut3 (
        .CLOCK_50 (clk),
        .KEY      ({1'b1, key[0]}),
        .SW       (sw3),
        .sel      (sel3),
        .mode     (1'b0),
        .LEDR     (ledr3),
        .ch       (ch3),
        .chg      (chg3)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        key  = 2'b10;
        sw   = 16'h4321;
        sel  = 2'd0;
        mode = 1'b0;
        sw3  = 12'hCBA;
        sel3 = 2'd1;
        #2;
        chk("rst_ledr", {12'h0, ledr}, 16'h0);
        chk("rst_ch",   {14'h0, ch},   16'h0);
        chk("rst_chg",  {15'h0, chg},  16'h0);
        tick(2);
        key[0] = 1'b1;

        // Direct select
        tick();
        chk("dir0_ch",   {14'h0, ch},   16'h0);
        chk("dir0_ledr", {12'h0, ledr}, 16'h1);
        chk("dir0_chg",  {15'h0, chg},  16'h0);
        chk("n3_ch1",    {14'h0, ch3},  16'h1);
        chk("n3_led1",   {12'h0, ledr3}, 16'hB);
        sel  = 2'd2;
        sel3 = 2'd3;
        tick();
        chk("dir2_ch",   {14'h0, ch},   16'h2);
        chk("dir2_ledr", {12'h0, ledr}, 16'h3);
        chk("dir2_chg",  {15'h0, chg},  16'h1);
        chk("n3_clamp_ch",   {14'h0, ch3},   16'h1);
        chk("n3_clamp_ledr", {12'h0, ledr3}, 16'hB);
        chk("n3_clamp_chg",  {15'h0, chg3},  16'h0);
        tick();
        chk("dir2_hold_chg", {15'h0, chg}, 16'h0);
        chk("dir2_hold_ch",  {14'h0, ch},  16'h2);
        sw = 16'h4A21;
        tick();
        chk("sw_follow", {12'h0, ledr}, 16'hA);
        chk("sw_nochg",  {15'h0, chg},  16'h0);
        sw = 16'h4321;
        tick();
        chk("sw_back", {12'h0, ledr}, 16'h3);

        // Auto-scan wrap 2 -> 3 -> 0 -> 1
        mode = 1'b1;
        tick();
        chk("scan_enter_ch", {14'h0, ch}, 16'h2);
        tick(3);
        chk("scan_wait3", {14'h0, ch}, 16'h2);
        tick();
        chk("scan3_ch",   {14'h0, ch},   16'h3);
        chk("scan3_ledr", {12'h0, ledr}, 16'h4);
        chk("scan3_chg",  {15'h0, chg},  16'h1);
        tick();
        chk("scan3_chg_off", {15'h0, chg}, 16'h0);
        tick(2);
        chk("scan_wait0", {14'h0, ch}, 16'h3);
        tick();
        chk("scan0_ch",   {14'h0, ch},   16'h0);
        chk("scan0_ledr", {12'h0, ledr}, 16'h1);
        chk("scan0_chg",  {15'h0, chg},  16'h1);
        tick(3);
        chk("scan_wait1", {14'h0, ch}, 16'h0);
        tick();
        chk("scan1_ch",   {14'h0, ch},   16'h1);
        chk("scan1_ledr", {12'h0, ledr}, 16'h2);
        chk("scan1_chg",  {15'h0, chg},  16'h1);

`ifdef MUX_SCAN_PAUSE_EN
        // Pause, hold 20 cycles, resume; next step exactly 4 cycles after resume
        key[1] = 1'b0;
        tick(3);
        chk("pause_enter_ch", {14'h0, ch}, 16'h1);
        key[1] = 1'b1;
        moved = 0;
        repeat (20) begin
            tick();
            if (ch !== 2'd1 || chg !== 1'b0) moved++;
        end
        chk("pause_frozen", 16'(moved), 16'h0);
        key[1] = 1'b0;
        tick(3);
        chk("resume_ch", {14'h0, ch}, 16'h1);
        key[1] = 1'b1;
        tick(3);
        chk("resume_wait", {14'h0, ch}, 16'h1);
        tick();
        chk("resume_step_ch",   {14'h0, ch},   16'h2);
        chk("resume_step_ledr", {12'h0, ledr}, 16'h3);
        chk("resume_step_chg",  {15'h0, chg},  16'h1);
`else
        // KEY[1] has no effect without the pause feature
        key[1] = 1'b0;
        tick(3);
        chk("key_ignored_wait", {14'h0, ch}, 16'h1);
        tick();
        chk("key_ignored_ch",  {14'h0, ch},  16'h2);
        chk("key_ignored_chg", {15'h0, chg}, 16'h1);
        key[1] = 1'b1;
`endif

        // mode 1->0 coinciding with a step pulse: mode wins
        key[1] = 1'b0;
        tick(2);
        mode = 1'b0;
        sel  = 2'd3;
        tick();
        chk("prio_ch",   {14'h0, ch},   16'h3);
        chk("prio_ledr", {12'h0, ledr}, 16'h4);
        chk("prio_chg",  {15'h0, chg},  16'h1);
        key[1] = 1'b1;
        tick();
        chk("prio_hold_ch",  {14'h0, ch},  16'h3);
        chk("prio_hold_chg", {15'h0, chg}, 16'h0);

        // Reset mid-scan, then restart scanning from channel 0
        sw   = 16'hFEDC;
        mode = 1'b1;
        tick(3);
        chk("prereset_ledr", {12'h0, ledr}, 16'hF);
        key[0] = 1'b0;
        #1;
        chk("async_rst_ledr", {12'h0, ledr}, 16'h0);
        chk("async_rst_ch",   {14'h0, ch},   16'h0);
        chk("async_rst_chg",  {15'h0, chg},  16'h0);
        tick();
        key[0] = 1'b1;
        tick();
        chk("restart_ch",   {14'h0, ch},   16'h0);
        chk("restart_ledr", {12'h0, ledr}, 16'hC);
        tick(3);
        chk("restart_wait", {14'h0, ch}, 16'h0);
        tick();
        chk("restart_step_ch",   {14'h0, ch},   16'h1);
        chk("restart_step_ledr", {12'h0, ledr}, 16'hD);
        chk("restart_step_chg",  {15'h0, chg},  16'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
